// File: rtl/rr_tag_arb.sv
// Round-robin arbiter: N masked requests -> one registered tag/rdy offer, held until ack or withdraw.
// Latency 1 cycle request->rdy, max one grant per 2 cycles; RR_TAG_ARB_STATS_EN adds saturating grant_cnt.
module rr_tag_arb #(
  parameter int N      = 4,
  parameter int TAG_SZ = 5,
  parameter int CNT_SZ = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [TAG_SZ-1:0] tag,
  output logic              rdy,
  input  logic              ack,
  input  logic [N-1:0]      rdy_in,
  output logic [N-1:0]      ack_out,
  input  logic [N-1:0]      en_mask
`ifdef RR_TAG_ARB_STATS_EN
  ,
  output logic [N*CNT_SZ-1:0] grant_cnt
`endif
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int NP = 1 << PW;

  if (N < 1 || N > 1024 || TAG_SZ < 1 || CNT_SZ < 1 ||
      (TAG_SZ < 11 && (1 << TAG_SZ) < N)) begin : g_param_chk
    $error("rr_tag_arb: illegal N / TAG_SZ / CNT_SZ combination");
  end

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   w_ptr_nxt;
  logic [PW-1:0]   r_sel;
  logic [PW-1:0]   w_sel_nxt;
  logic [NP-1:0]   w_elig;
  logic [NP-1:0]   w_req;
  logic [PW:0]     w_idx;
  logic [PW-1:0]   w_pick;
  logic            w_found;
  logic            w_accept;

  // Padded to a power of two so the PW-bit channel index always fits exactly.
  assign w_elig = NP'(rdy_in & en_mask);
  assign w_req  = NP'(rdy_in);

  // Walk offsets from the far end so the closest eligible channel to r_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = {1'b0, r_ptr} + (PW + 1)'(i);
      if (w_idx >= (PW + 1)'(N)) begin
        w_idx = w_idx - (PW + 1)'(N);
      end
      if (w_elig[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_sel_nxt   = w_pick;
          w_state_nxt = S_OFFER;
        end
      end
      S_OFFER: begin
        if (!w_req[r_sel]) begin
          w_state_nxt = S_IDLE;
        end else if (ack) begin
          w_accept    = 1'b1;
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = (r_sel == PW'(N - 1)) ? '0 : r_sel + PW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  assign rdy     = (r_state == S_OFFER);
  assign tag     = TAG_SZ'(r_sel);
  assign ack_out = w_accept ? (N'(1) << r_sel) : '0;

`ifdef RR_TAG_ARB_STATS_EN
  logic [N-1:0][CNT_SZ-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (ack_out[k] && (r_cnt[k] != {CNT_SZ{1'b1}})) begin
          r_cnt[k] <= r_cnt[k] + CNT_SZ'(1);
        end
      end
    end
  end

  assign grant_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_rr_tag_arb.sv
// Bench for rr_tag_arb (N=4): directed vector table, reset/stat sequences, randomized run vs a reference model.
module tb_rr_tag_arb;

  localparam int NCH = 4;
  localparam int CSZ = 2;
  localparam int CMAX = 3;

  logic                clk;
  logic                rst;
  logic [4:0]          tag;
  logic                rdy;
  logic                ack;
  logic [NCH-1:0]      rdy_in;
  logic [NCH-1:0]      ack_out;
  logic [NCH-1:0]      en_mask;
`ifdef RR_TAG_ARB_STATS_EN
  logic [NCH*CSZ-1:0]  grant_cnt;
`endif

  rr_tag_arb #(.N(NCH), .TAG_SZ(5), .CNT_SZ(CSZ)) dut (
    .clk      (clk),
    .rst      (rst),
    .tag      (tag),
    .rdy      (rdy),
    .ack      (ack),
    .rdy_in   (rdy_in),
    .ack_out  (ack_out),
    .en_mask  (en_mask)
`ifdef RR_TAG_ARB_STATS_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: arbitration state described directly by its rules.
  int m_busy, m_tag, m_ptr;
  int m_cnt[NCH];

  task automatic model_reset();
    m_busy = 0; m_tag = 0; m_ptr = 0;
    for (int k = 0; k < NCH; k++) m_cnt[k] = 0;
  endtask

  function automatic logic [NCH-1:0] model_ack(input logic [NCH-1:0] rin, input logic ak);
    if (m_busy != 0 && ak && rin[m_tag]) return NCH'(1) << m_tag;
    return '0;
  endfunction

  task automatic model_step(input logic [NCH-1:0] rin, input logic [NCH-1:0] en, input logic ak);
    int found;
    found = 0;
    if (m_busy == 0) begin
      for (int i = 0; i < NCH; i++) begin
        int k;
        k = (m_ptr + i) % NCH;
        if (found == 0 && rin[k] && en[k]) begin
          found = 1; m_tag = k; m_busy = 1;
        end
      end
    end else if (!rin[m_tag]) begin
      m_busy = 0;
    end else if (ak) begin
      m_busy = 0;
      m_ptr  = (m_tag + 1) % NCH;
      if (m_cnt[m_tag] < CMAX) m_cnt[m_tag]++;
    end
  endtask

  typedef struct {
    logic [3:0] rin;
    logic [3:0] en;
    logic       ak;
    logic       erdy;
    int         etag;
    logic [3:0] eao;
  } vec_t;

  vec_t tbl[26];

  initial begin
    tbl[0]  = '{4'b0100, 4'hF,    1'b0, 1'b0, 0, 4'b0000};
    tbl[1]  = '{4'b0100, 4'hF,    1'b1, 1'b1, 2, 4'b0100};
    tbl[2]  = '{4'b0000, 4'hF,    1'b0, 1'b0, 2, 4'b0000};
    tbl[3]  = '{4'b1001, 4'hF,    1'b0, 1'b0, 2, 4'b0000};
    tbl[4]  = '{4'b1001, 4'hF,    1'b1, 1'b1, 3, 4'b1000};
    tbl[5]  = '{4'b0001, 4'hF,    1'b0, 1'b0, 3, 4'b0000};
    tbl[6]  = '{4'b0001, 4'hF,    1'b1, 1'b1, 0, 4'b0001};
    tbl[7]  = '{4'b1111, 4'hF,    1'b1, 1'b0, 0, 4'b0000};
    tbl[8]  = '{4'b1111, 4'hF,    1'b1, 1'b1, 1, 4'b0010};
    tbl[9]  = '{4'b1111, 4'hF,    1'b1, 1'b0, 1, 4'b0000};
    tbl[10] = '{4'b1111, 4'hF,    1'b1, 1'b1, 2, 4'b0100};
    tbl[11] = '{4'b1111, 4'hF,    1'b1, 1'b0, 2, 4'b0000};
    tbl[12] = '{4'b1111, 4'hF,    1'b1, 1'b1, 3, 4'b1000};
    tbl[13] = '{4'b1111, 4'hF,    1'b1, 1'b0, 3, 4'b0000};
    tbl[14] = '{4'b1111, 4'hF,    1'b1, 1'b1, 0, 4'b0001};
    tbl[15] = '{4'b0010, 4'hF,    1'b0, 1'b0, 0, 4'b0000};
    tbl[16] = '{4'b0000, 4'hF,    1'b0, 1'b1, 1, 4'b0000};
    tbl[17] = '{4'b0011, 4'hF,    1'b0, 1'b0, 1, 4'b0000};
    tbl[18] = '{4'b0011, 4'hF,    1'b1, 1'b1, 1, 4'b0010};
    tbl[19] = '{4'b0011, 4'b0010, 1'b0, 1'b0, 1, 4'b0000};
    tbl[20] = '{4'b0011, 4'b0000, 1'b0, 1'b1, 1, 4'b0000};
    tbl[21] = '{4'b0011, 4'b0000, 1'b1, 1'b1, 1, 4'b0010};
    tbl[22] = '{4'b0011, 4'b0000, 1'b0, 1'b0, 1, 4'b0000};
    tbl[23] = '{4'b0001, 4'hF,    1'b0, 1'b0, 1, 4'b0000};
    tbl[24] = '{4'b0000, 4'hF,    1'b1, 1'b1, 0, 4'b0000};
    tbl[25] = '{4'b0000, 4'hF,    1'b0, 1'b0, 0, 4'b0000};
  end

  task automatic release_reset();
    ack = 1'b0; rdy_in = '0;
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NCH-1:0] e_ao;
    rst = 1'b0; ack = 1'b0; rdy_in = '0; en_mask = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdy", 32'(rdy), 32'd0);
    chk("reset_tag", 32'(tag), 32'd0);
    chk("reset_ack_out", 32'(ack_out), 32'd0);
`ifdef RR_TAG_ARB_STATS_EN
    chk("reset_grant_cnt", 32'(grant_cnt), 32'd0);
`endif
    rst = 1'b1;

    for (int i = 0; i < 26; i++) begin
      rdy_in = tbl[i].rin; en_mask = tbl[i].en; ack = tbl[i].ak;
      #4;
      chk($sformatf("vec%0d_rdy", i), 32'(rdy), 32'(tbl[i].erdy));
      chk($sformatf("vec%0d_tag", i), 32'(tag), 32'(tbl[i].etag));
      chk($sformatf("vec%0d_ack_out", i), 32'(ack_out), 32'(tbl[i].eao));
      model_step(rdy_in, en_mask, ack);
      @(posedge clk);
      #1;
    end

    // Reset while offering: outputs must collapse before the next clock edge.
    rdy_in = 4'b0100; en_mask = 4'hF; ack = 1'b0;
    @(posedge clk);
    #1 ack = 1'b1;
    #1;
    chk("midoffer_rdy", 32'(rdy), 32'd1);
    chk("midoffer_ack_out", 32'(ack_out), 32'b0100);
    rst = 1'b0;
    #1;
    chk("async_rst_rdy", 32'(rdy), 32'd0);
    chk("async_rst_ack_out", 32'(ack_out), 32'd0);
    chk("async_rst_tag", 32'(tag), 32'd0);
    model_reset();
    release_reset();

`ifdef RR_TAG_ARB_STATS_EN
    for (int g = 0; g < 5; g++) begin
      rdy_in = 4'b0001; en_mask = 4'hF; ack = 1'b0;
      #4;
      model_step(rdy_in, en_mask, ack);
      @(posedge clk);
      #1 ack = 1'b1;
      #4;
      chk($sformatf("stat%0d_ack_out", g), 32'(ack_out), 32'b0001);
      model_step(rdy_in, en_mask, ack);
      @(posedge clk);
      #1;
      chk($sformatf("stat%0d_cnt0", g), 32'(grant_cnt[1:0]), (g + 1 > CMAX) ? CMAX : g + 1);
      chk($sformatf("stat%0d_cnt_others", g), 32'(grant_cnt[7:2]), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("stat_cleared_by_reset", 32'(grant_cnt), 32'd0);
    model_reset();
    release_reset();
`endif

    for (int c = 0; c < 600; c++) begin
      rdy_in  = NCH'($urandom_range(0, 15));
      en_mask = ($urandom_range(0, 3) == 0) ? NCH'($urandom_range(0, 15)) : 4'hF;
      ack     = 1'($urandom_range(0, 1));
      #4;
      e_ao = model_ack(rdy_in, ack);
      chk($sformatf("rnd%0d_rdy", c), 32'(rdy), 32'(m_busy));
      chk($sformatf("rnd%0d_tag", c), 32'(tag), 32'(m_tag));
      chk($sformatf("rnd%0d_ack_out", c), 32'(ack_out), 32'(e_ao));
      model_step(rdy_in, en_mask, ack);
      @(posedge clk);
      #1;
    end
`ifdef RR_TAG_ARB_STATS_EN
    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("rnd_cnt%0d", k), 32'(grant_cnt[k*CSZ +: CSZ]), 32'(m_cnt[k]));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_tag_arb.md
Name: rr_tag_arb

Overview:
- Parametrised round-robin successor to the snoop-arbitration tag tree.
- Arbitrates N rdy/ack sources into a single registered tag/rdy/ack stream for the snoop arbiter.
- Adds two things the fixed-priority tree lacks: rotating fairness and a per-channel enable mask.
- Output tag and rdy are registered; the grant is held stable until the downstream ack.

Parameters:
N, 4, number of request channels (1..1024; N=1 legal, tag fixed at 0)
TAG_SZ, 5, tag width; 2^TAG_SZ >= N required, checked at elaboration
CNT_SZ, 16, width of each grant counter (optional feature only)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset; deassertion is synchronous to clk at the system level
tag  output  TAG_SZ  index of the granted channel, zero-extended
rdy  output  1  tag valid, offered downstream
ack  input  1  downstream accepts the offered tag; counts only when rdy=1
rdy_in  input  N  per-channel request
ack_out  output  N  per-channel acknowledge, one-hot or zero
en_mask  input  N  1 = channel eligible for new grants
grant_cnt  output  N*CNT_SZ  per-channel accepted-grant counts, channel k at [k*CNT_SZ +: CNT_SZ] (RR_TAG_ARB_STATS_EN only)

Behaviour:
- Reset (rst=0, async): state=IDLE, rdy=0, tag=0, ack_out=0, round-robin pointer ptr=0, grant_cnt=0.
- Eligibility: eligible[k] = rdy_in[k] & en_mask[k].
- State IDLE:
  - Search for the first eligible channel in rotating order ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - If one is found: register tag=w and go to OFFER; rdy=1 from the next cycle.
  - If none is found: stay in IDLE with rdy=0. tag holds its last value.
- State OFFER (rdy=1): tag is held constant.
  - ack=1 and rdy_in[w]=1 (accept):
    - ack_out[w]=1 combinationally in the same cycle; all other ack_out bits are 0.
    - Next cycle: ptr=(w+1) mod N, state=IDLE, rdy=0.
  - rdy_in[w]=0 (withdraw), regardless of ack:
    - No ack_out is issued.
    - Next cycle: state=IDLE, rdy=0, ptr unchanged.
  - Otherwise: stay in OFFER.
- Throughput: at most one grant per 2 cycles (OFFER, IDLE, OFFER...).
- Latency: 1 cycle from an eligible rdy_in in IDLE to rdy=1.
- Source rule: a source must drop rdy_in the cycle after its ack_out unless it has another item. A source that keeps rdy_in high is re-eligible, with lowest priority after ptr advances.
- en_mask changes:
  - Affect only the next selection in IDLE.
  - Clearing en_mask[w] during OFFER does not revoke the current offer.
- ptr wrap: when w=N-1, ptr becomes 0.
- N=1: tag=0 always. The state machine is unchanged, so rdy=0 still appears for one cycle between grants.
- ack while rdy=0: ignored; no ack_out, no state change.
- Reset asserted mid-OFFER: rdy and ack_out drop immediately (async), and the grant is lost. Sources re-request after reset.

Optional Feature:
- Macro RR_TAG_ARB_STATS_EN.
- Defined:
  - The grant_cnt port exists.
  - Counter k increments on each accepted grant to k (the ack_out[k] cycle) and saturates at 2^CNT_SZ-1.
  - Counters are cleared by reset only.
- Undefined:
  - The port and counters are absent.
  - All other behaviour is identical, cycle for cycle.

Test Plan:
- Reset, then rdy_in=4'b0100, en_mask=4'hF -> rdy=1 one cycle later with tag=2. Pulse ack -> ack_out=4'b0100 same cycle, then rdy=0 next cycle, ptr=3.
- rdy_in=4'hF held, en_mask=4'hF, ack pulsed on each OFFER -> tags 0,1,2,3,0,... with rdy high every other cycle, and no channel granted twice within 4 grants.
- ptr=3, rdy_in=4'b1001 -> tag=3. After ack, ptr=0 (wrap), next grant is tag=0.
- rdy_in=4'b0011, en_mask=4'b0010 -> tag=1 only. Clear en_mask[1] during OFFER -> offer persists and ack still gives ack_out=4'b0010.
- In OFFER with tag=1, drop rdy_in[1] with ack=0 -> rdy=0 next cycle, no ack_out, and channel 1 is still first candidate for the next selection if it re-requests (ptr unchanged). Assert rst=0 mid-OFFER -> rdy=0 and ack_out=0 immediately, before the next clock edge.
- With RR_TAG_ARB_STATS_EN, CNT_SZ=2: grant channel 0 five times -> grant_cnt[1:0]=3 (saturated). Other counters 0, and all return to 0 after reset.
